// File: rtl/inv_resp_checker_pkg.sv
// inv_chk_pkg: shared types and helpers for the inverter response checker.
//   state_t  : run FSM encoding (IDLE/FILL/CHECK/DONE)
//   LAT_MAX  : largest supported stimulus-to-response latency
//   HIST_W   : width of the optional mismatch history (INV_CHK_HIST_EN)
//   sat_inc  : increment that sticks at a given maximum
package inv_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned LAT_MAX = 15;
   localparam int unsigned HIST_W  = 16;

   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/inv_resp_checker_if.sv
// inv_resp_checker_if: run-control, sample and report signals of the checker.
//   master : drives I_start/I_sample_en/I_stim/I_resp, observes the report
//   slave  : the checker side
//   O_hist exists only when INV_CHK_HIST_EN is defined.
interface inv_resp_checker_if
   import inv_chk_pkg::*;
#(
   parameter int unsigned CNT_W = 8
);
   logic             I_start;
   logic             I_sample_en;
   logic             I_stim;
   logic             I_resp;
   logic             O_busy;
   logic             O_done;
   logic             O_pass;
   logic [CNT_W-1:0] O_sample_cnt;
   logic [CNT_W-1:0] O_err_cnt;
   logic [CNT_W-1:0] O_first_fail_idx;
   logic             O_first_fail_vld;
`ifdef INV_CHK_HIST_EN
   logic [HIST_W-1:0] O_hist;
`endif

   modport master (
      output I_start, I_sample_en, I_stim, I_resp,
      input  O_busy, O_done, O_pass, O_sample_cnt, O_err_cnt,
             O_first_fail_idx, O_first_fail_vld
`ifdef INV_CHK_HIST_EN
      , input O_hist
`endif
   );

   modport slave (
      input  I_start, I_sample_en, I_stim, I_resp,
      output O_busy, O_done, O_pass, O_sample_cnt, O_err_cnt,
             O_first_fail_idx, O_first_fail_vld
`ifdef INV_CHK_HIST_EN
      , output O_hist
`endif
   );

endinterface

// File: rtl/inv_resp_checker_dly.sv
// inv_chk_dly: LATENCY-deep stimulus delay line.
//   clk  : rising-edge clock
//   clr  : synchronous clear to all-zero
//   en   : shift one position
//   din  : bit entering the line
//   dout : bit delayed LATENCY shifts (din itself when LATENCY = 0)
module inv_chk_dly #(
   parameter int unsigned LATENCY = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic dout
);

   generate
      if (LATENCY == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = clk ^ clr ^ en;
         assign dout      = din;
      end else begin : g_sr
         logic [LATENCY-1:0] sr;
         always_ff @(posedge clk) begin
            if (clr)
               sr <= '0;
            else if (en)
               // truncating cast drops the oldest bit; valid for LATENCY = 1 too
               sr <= LATENCY'({sr, din});
         end
         assign dout = sr[LATENCY-1];
      end
   endgenerate

endmodule

// File: rtl/inv_resp_checker.sv
// inv_resp_checker: compares an inverter cell's output with the inverse of
// its stimulus delayed by LATENCY samples, over N_SAMPLES compared samples.
//   I_clock : rising-edge clock
//   I_reset : synchronous active-high reset
//   bus     : inv_resp_checker_if.slave (start/sample inputs, report outputs)
// Optional: INV_CHK_HIST_EN adds bus.O_hist, a per-sample mismatch history.
module inv_resp_checker
   import inv_chk_pkg::*;
#(
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned N_SAMPLES = 6,
   parameter int unsigned CNT_W     = 8
) (
   input  logic               I_clock,
   input  logic               I_reset,
   inv_resp_checker_if.slave  bus
);

   localparam logic [3:0]       FILL_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_SAMPLES - 1);
   localparam logic [CNT_W-1:0] ALL_ONES  = '1;

   state_t           state_q, state_d;
   logic [3:0]       fill_q, fill_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] ffi_q, ffi_d;
   logic             ffv_q, ffv_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
`ifdef INV_CHK_HIST_EN
   logic [HIST_W-1:0] hist_q, hist_d;
`endif

   logic run_start;
   logic shift_en;
   logic mism;
   logic dly_out;

   inv_chk_dly #(.LATENCY(LATENCY)) u_dly (
      .clk  (I_clock),
      .clr  (I_reset | run_start),
      .en   (shift_en),
      .din  (bus.I_stim),
      .dout (dly_out)
   );

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      scnt_d    = scnt_q;
      err_d     = err_q;
      ffi_d     = ffi_q;
      ffv_d     = ffv_q;
`ifdef INV_CHK_HIST_EN
      hist_d    = hist_q;
`endif
      run_start = 1'b0;
      shift_en  = 1'b0;
      mism      = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            // a start wins over a coincident sample, which is dropped
            if (bus.I_start) begin
               run_start = 1'b1;
               state_d   = (LATENCY > 0) ? FILL : CHECK;
               fill_d    = '0;
               scnt_d    = '0;
               err_d     = '0;
               ffi_d     = '0;
               ffv_d     = 1'b0;
`ifdef INV_CHK_HIST_EN
               hist_d    = '0;
`endif
            end
         end
         FILL: begin
            if (bus.I_sample_en) begin
               shift_en = 1'b1;
               fill_d   = fill_q + 4'd1;
               if (fill_q == FILL_LAST)
                  state_d = CHECK;
            end
         end
         CHECK: begin
            if (bus.I_sample_en) begin
               shift_en = 1'b1;
               // case equality so an X/Z response is never taken as a match
               mism     = !(bus.I_resp === ~dly_out);
               scnt_d   = scnt_q + 1'b1;
               if (mism) begin
                  err_d = CNT_W'(sat_inc(32'(err_q), 32'(ALL_ONES)));
                  if (!ffv_q) begin
                     ffv_d = 1'b1;
                     ffi_d = scnt_q;
                  end
               end
`ifdef INV_CHK_HIST_EN
               hist_d = {hist_q[HIST_W-2:0], mism};
`endif
               if (scnt_q == LAST_IDX)
                  state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == FILL) || (state_d == CHECK);
      done_d = (state_d == DONE);
      pass_d = (state_d == DONE) && (err_d == '0);
   end

   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         state_q <= IDLE;
         fill_q  <= '0;
         scnt_q  <= '0;
         err_q   <= '0;
         ffi_q   <= '0;
         ffv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef INV_CHK_HIST_EN
         hist_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         scnt_q  <= scnt_d;
         err_q   <= err_d;
         ffi_q   <= ffi_d;
         ffv_q   <= ffv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef INV_CHK_HIST_EN
         hist_q  <= hist_d;
`endif
      end
   end

   assign bus.O_busy           = busy_q;
   assign bus.O_done           = done_q;
   assign bus.O_pass           = pass_q;
   assign bus.O_sample_cnt     = scnt_q;
   assign bus.O_err_cnt        = err_q;
   assign bus.O_first_fail_idx = ffi_q;
   assign bus.O_first_fail_vld = ffv_q;
`ifdef INV_CHK_HIST_EN
   assign bus.O_hist           = hist_q;
`endif

endmodule

// File: tb/tb_inv_resp_checker.sv
// Scoreboard bench for inv_resp_checker: three instances
//   u0 LATENCY=1 N_SAMPLES=6  CNT_W=8
//   u1 LATENCY=0 N_SAMPLES=6  CNT_W=8
//   u2 LATENCY=1 N_SAMPLES=15 CNT_W=4
// Each run pushes its expected report; per-instance monitors pop on O_done rise.
module tb_inv_resp_checker;

   typedef struct {
      logic        pass;
      logic [31:0] scnt;
      logic [31:0] err;
      logic [31:0] ffi;
      logic        ffv;
      logic [15:0] hist;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t e0, e1, e2;
   logic dprev0 = 1'b0, dprev1 = 1'b0, dprev2 = 1'b0;

   always #5 clk = ~clk;

   inv_resp_checker_if #(.CNT_W(8)) if0 ();
   inv_resp_checker_if #(.CNT_W(8)) if1 ();
   inv_resp_checker_if #(.CNT_W(4)) if2 ();

   inv_resp_checker #(.LATENCY(1), .N_SAMPLES(6), .CNT_W(8)) u0 (
      .I_clock(clk), .I_reset(rst), .bus(if0.slave));
   inv_resp_checker #(.LATENCY(0), .N_SAMPLES(6), .CNT_W(8)) u1 (
      .I_clock(clk), .I_reset(rst), .bus(if1.slave));
   inv_resp_checker #(.LATENCY(1), .N_SAMPLES(15), .CNT_W(4)) u2 (
      .I_clock(clk), .I_reset(rst), .bus(if2.slave));

   logic [15:0] h0, h1, h2;
`ifdef INV_CHK_HIST_EN
   assign h0 = if0.O_hist;
   assign h1 = if1.O_hist;
   assign h2 = if2.O_hist;
`else
   assign h0 = '0;
   assign h1 = '0;
   assign h2 = '0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic cmp_rep(input string tag, input exp_t e, input logic pass,
                          input logic [31:0] scnt, input logic [31:0] err,
                          input logic [31:0] ffi, input logic ffv, input logic [15:0] hist);
      chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
      chk({tag, "_sample_cnt"}, scnt, e.scnt);
      chk({tag, "_err_cnt"}, err, e.err);
      chk({tag, "_first_fail_idx"}, ffi, e.ffi);
      chk({tag, "_first_fail_vld"}, 32'(ffv), 32'(e.ffv));
`ifdef INV_CHK_HIST_EN
      chk({tag, "_hist"}, 32'(hist), 32'(e.hist));
`else
      if (hist !== 16'h0) begin
         checks++;
         errors++;
         $display("FAIL %s_hist: got %0h required 0", tag, hist);
      end
`endif
   endtask

   task automatic spurious(input string tag);
      checks++;
      errors++;
      $display("FAIL %s_done: got unexpected done, required none", tag);
   endtask

   // monitors
   always @(negedge clk) begin
      if (if0.O_done === 1'b1 && dprev0 !== 1'b1) begin
         if (q0.size() == 0) spurious("u0");
         else begin
            e0 = q0.pop_front();
            cmp_rep("u0", e0, if0.O_pass, 32'(if0.O_sample_cnt), 32'(if0.O_err_cnt),
                    32'(if0.O_first_fail_idx), if0.O_first_fail_vld, h0);
         end
      end
      dprev0 = if0.O_done;
   end

   always @(negedge clk) begin
      if (if1.O_done === 1'b1 && dprev1 !== 1'b1) begin
         if (q1.size() == 0) spurious("u1");
         else begin
            e1 = q1.pop_front();
            cmp_rep("u1", e1, if1.O_pass, 32'(if1.O_sample_cnt), 32'(if1.O_err_cnt),
                    32'(if1.O_first_fail_idx), if1.O_first_fail_vld, h1);
         end
      end
      dprev1 = if1.O_done;
   end

   always @(negedge clk) begin
      if (if2.O_done === 1'b1 && dprev2 !== 1'b1) begin
         if (q2.size() == 0) spurious("u2");
         else begin
            e2 = q2.pop_front();
            cmp_rep("u2", e2, if2.O_pass, 32'(if2.O_sample_cnt), 32'(if2.O_err_cnt),
                    32'(if2.O_first_fail_idx), if2.O_first_fail_vld, h2);
         end
      end
      dprev2 = if2.O_done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int u);
      case (u)
         0: if0.I_start = 1'b1;
         1: if1.I_start = 1'b1;
         default: if2.I_start = 1'b1;
      endcase
      tick();
      if0.I_start = 1'b0;
      if1.I_start = 1'b0;
      if2.I_start = 1'b0;
   endtask

   // one qualified sample followed by an unqualified gap cycle with junk inputs
   task automatic samp(input int u, input logic s, input logic r, input logic st);
      case (u)
         0: begin if0.I_sample_en = 1'b1; if0.I_stim = s; if0.I_resp = r; if0.I_start = st; end
         1: begin if1.I_sample_en = 1'b1; if1.I_stim = s; if1.I_resp = r; if1.I_start = st; end
         default: begin if2.I_sample_en = 1'b1; if2.I_stim = s; if2.I_resp = r; if2.I_start = st; end
      endcase
      tick();
      case (u)
         0: begin if0.I_sample_en = 1'b0; if0.I_stim = ~s; if0.I_resp = 1'bx; if0.I_start = 1'b0; end
         1: begin if1.I_sample_en = 1'b0; if1.I_stim = ~s; if1.I_resp = 1'bx; if1.I_start = 1'b0; end
         default: begin if2.I_sample_en = 1'b0; if2.I_stim = ~s; if2.I_resp = 1'bx; if2.I_start = 1'b0; end
      endcase
      tick();
   endtask

   // u0 run: fill sample then 6 compared samples; bad<0 means no corruption
   task automatic run0(input int bad, input bit noise, input bit abort);
      logic p [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic r;
      exp_t e;
      if (!abort) begin
         e.pass = (bad < 0);
         e.scnt = 32'd6;
         e.err  = (bad < 0) ? 32'd0 : 32'd1;
         e.ffi  = (bad < 0) ? 32'd0 : 32'(bad);
         e.ffv  = (bad >= 0);
         e.hist = (bad < 0) ? 16'h0 : (16'h1 << (5 - bad));
         q0.push_back(e);
      end
      pulse_start(0);
      for (int i = 0; i < 7; i++) begin
         if (abort && i == 4) break;
         if (i == 0)             r = 1'b0;
         else if (i - 1 == bad)  r = p[i-1];
         else                    r = ~p[i-1];
         samp(0, p[i], r, noise && (i == 0 || i == 3));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      if0.I_start = 1'b0; if0.I_sample_en = 1'b0; if0.I_stim = 1'b0; if0.I_resp = 1'b0;
      if1.I_start = 1'b0; if1.I_sample_en = 1'b0; if1.I_stim = 1'b0; if1.I_resp = 1'b0;
      if2.I_start = 1'b0; if2.I_sample_en = 1'b0; if2.I_stim = 1'b0; if2.I_resp = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_busy", 32'(if0.O_busy), 0);
      chk("rst_done", 32'(if0.O_done), 0);
      chk("rst_pass", 32'(if0.O_pass), 0);
      chk("rst_scnt", 32'(if0.O_sample_cnt), 0);
      chk("rst_err", 32'(if0.O_err_cnt), 0);
      chk("rst_ffv", 32'(if0.O_first_fail_vld), 0);
      chk("rst_u1_busy", 32'(if1.O_busy), 0);
      chk("rst_u2_done", 32'(if2.O_done), 0);

      // clean run with starts during FILL and CHECK (ignored)
      run0(-1, 1'b1, 1'b0);
      // mismatch on the third compared sample
      run0(2, 1'b0, 1'b0);

      // start from DONE clears the report and goes busy
      pulse_start(0);
      chk("restart_busy", 32'(if0.O_busy), 1);
      chk("restart_done", 32'(if0.O_done), 0);
      chk("restart_scnt", 32'(if0.O_sample_cnt), 0);
      chk("restart_err", 32'(if0.O_err_cnt), 0);
      chk("restart_ffv", 32'(if0.O_first_fail_vld), 0);
      run0(-1, 1'b0, 1'b0);   // its own start pulse lands while busy

      // reset after three compared samples aborts silently
      run0(-1, 1'b0, 1'b1);
      chk("abort_busy_pre", 32'(if0.O_busy), 1);
      chk("abort_scnt_pre", 32'(if0.O_sample_cnt), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(if0.O_busy), 0);
      chk("abort_done", 32'(if0.O_done), 0);
      chk("abort_pass", 32'(if0.O_pass), 0);
      chk("abort_scnt", 32'(if0.O_sample_cnt), 0);
      chk("abort_err", 32'(if0.O_err_cnt), 0);
      chk("abort_ffi", 32'(if0.O_first_fail_idx), 0);
      chk("abort_ffv", 32'(if0.O_first_fail_vld), 0);
      run0(-1, 1'b0, 1'b0);

      // LATENCY=0, response stuck at 1, stimulus 1,0,1,0,1,0
      e.pass = 1'b0; e.scnt = 32'd6; e.err = 32'd3; e.ffi = 32'd0; e.ffv = 1'b1; e.hist = 16'h002A;
      q1.push_back(e);
      pulse_start(1);
      for (int i = 0; i < 6; i++) samp(1, (i % 2 == 0), 1'b1, 1'b0);

      // CNT_W=4, 15 samples, every response wrong: count reaches 15 without wrap
      e.pass = 1'b0; e.scnt = 32'd15; e.err = 32'd15; e.ffi = 32'd0; e.ffv = 1'b1; e.hist = 16'h7FFF;
      q2.push_back(e);
      pulse_start(2);
      for (int i = 0; i < 16; i++) samp(2, 1'b1, 1'b1, 1'b0);

      repeat (4) tick();
      chk("u0_reports_pending", 32'(q0.size()), 0);
      chk("u1_reports_pending", 32'(q1.size()), 0);
      chk("u2_reports_pending", 32'(q2.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
